hw_qsys_cpu_1_cpu_debug_ocimem: RTL and testbench
=================================================

# hw_qsys_cpu_1_cpu_debug_ocimem

On-chip debug memory (OCI memory) controller for the Nios II debug core. It sits downstream of the debug-slave sysclk stage and consumes its `jdo` payload and single-cycle `take_action_ocimem_*` / `take_no_action_ocimem_a` strobes. It owns a word-addressed debug RAM shared between the JTAG path and a CPU-side Avalon slave port. It returns `MonDReg`, `monitor_ready` and `monitor_error` to the debug-slave TCK stage for scan-out.

## Interface
Parameters:
- `ADDR_W`, default 8: debug RAM word-address width (depth 2^ADDR_W x 32).

Ports:
- `clk`  in  1: system clock; all logic is in this domain.
- `reset_n`  in  1: asynchronous, active-low reset.
- `jdo`  in  38: JTAG data payload from the sysclk stage; valid only in a cycle with a strobe.
- `take_action_ocimem_a`  in  1: address-load command strobe.
- `take_action_ocimem_b`  in  1: write-data command strobe.
- `take_no_action_ocimem_a`  in  1: status-clear strobe.
- `cpu_address`  in  ADDR_W: CPU word address.
- `cpu_read`, `cpu_write`  in  1: CPU access requests.
- `cpu_writedata`  in  32: CPU write data.
- `cpu_byteenable`  in  4: CPU byte lanes.
- `cpu_debugaccess`  in  1: CPU writes are accepted only when this is 1.
- `cpu_readdata`  out  32: CPU read data, fixed read latency 1.
- `cpu_waitrequest`  out  1: CPU stall.
- `MonAReg`  out  ADDR_W: JTAG access pointer.
- `MonDReg`  out  32: JTAG data register.
- `monitor_ready`  out  1: sticky flag, set when a JTAG access completes.
- `monitor_error`  out  1: sticky flag, set when a JTAG command is dropped.

## Operation
- jdo fields:
  - address = `jdo[17:10]`, low ADDR_W bits used.
  - read-after-load = `jdo[25]`.
  - write data = `jdo[34:3]`.
  - clear-ready = `jdo[34]`; clear-error = `jdo[35]` (status-clear strobe only).
- FSM states: IDLE, RD, RD_WAIT, WR. All outputs reset to 0 and the FSM resets to IDLE.
- IDLE + `take_action_ocimem_a`:
  - `MonAReg` <= address; `monitor_ready` <= 0.
  - If read-after-load = 1, go to RD; otherwise stay in IDLE and set `monitor_ready` <= 1.
- IDLE + `take_action_ocimem_b`: `MonDReg` <= write data; `monitor_ready` <= 0; go to WR.
- RD: drive RAM read at `MonAReg`; go to RD_WAIT.
- RD_WAIT: `MonDReg` <= RAM q; `MonAReg` += 1; `monitor_ready` <= 1; go to IDLE.
- WR: write `MonDReg` at `MonAReg` with all byte lanes; `MonAReg` += 1; `monitor_ready` <= 1; go to IDLE.
- `MonAReg` increments modulo 2^ADDR_W; 2^ADDR_W-1 wraps to 0.
- Any `take_action_ocimem_a/b` strobe outside IDLE is dropped, with `monitor_error` <= 1. The FSM state is unaffected.
- If `take_action_ocimem_a` and `take_action_ocimem_b` arrive in the same cycle: `a` executes, `b` is dropped, and `monitor_error` <= 1.
- `take_no_action_ocimem_a` is accepted in any state and clears the selected flags.
  - If it coincides with a set event, the set event wins.
- CPU port:
  - An access is accepted only in IDLE with no JTAG action strobe that cycle; otherwise `cpu_waitrequest` = 1.
  - A write with `cpu_debugaccess` = 0 is accepted, not stalled, and discarded.
  - A CPU write never modifies `MonDReg` or `MonAReg`.

## Timing
- Let E0 be the clock edge that samples the strobe.
- Address-load with read-after-load: RAM read at E1, `MonDReg`/`monitor_ready` visible after E2.
- Write: RAM updated at E1; `monitor_ready` visible after E1.
- Address-load without read: `monitor_ready` visible after E0.
- `cpu_waitrequest` is combinational from `cpu_read`/`cpu_write`, the FSM state and the strobes.
- `cpu_readdata` is valid the cycle after the accepted read and holds until the next accepted read.
- Reset mid-operation:
  - The FSM returns to IDLE and all flags and registers clear.
  - RAM contents are undefined after reset and are not cleared.

## Configuration
- Macro `HW_QSYS_OCIMEM_PARITY_EN`.
- Defined:
  - The RAM stores one even-parity bit per byte (36 bits per word).
  - A parity mismatch on a JTAG read (RD_WAIT) sets `monitor_error` while still loading `MonDReg`.
  - A mismatch on a CPU read is ignored.
- Undefined: the RAM is 32 bits wide and `monitor_error` has no parity source.

## Structure
- Shared package holds:
  - jdo field bit positions;
  - the FSM state enum (IDLE, RD, RD_WAIT, WR);
  - the parity-width constant.
- One sub-module, `hw_qsys_cpu_1_cpu_debug_ocimem_ram`:
  - single-port synchronous RAM with byte enables and registered q;
  - width depends on `HW_QSYS_OCIMEM_PARITY_EN`.
- The mux between JTAG and CPU addresses lives in the top module.

## Test plan
- JTAG load+read: ocimem_a with address 0x10 and read flag, RAM[0x10] = 0xDEADBEEF -> `MonDReg` = 0xDEADBEEF, `monitor_ready` = 1 two edges later, `MonAReg` = 0x11.
- JTAG write burst at wrap: load 0xFF with no read, then two ocimem_b strobes with 0x11111111 and 0x22222222 -> RAM[0xFF] = 0x11111111, RAM[0x00] = 0x22222222, `MonAReg` = 0x01.
- Busy collision: ocimem_b one cycle after a read-load -> `monitor_error` = 1, RAM unchanged, read completes normally; then ocimem_no_action with jdo[35] = 1 -> `monitor_error` = 0.
- CPU arbitration: CPU read of 0x20 issued in the same cycle as an ocimem_a strobe -> `cpu_waitrequest` = 1 until the FSM returns to IDLE, then correct data one cycle after accept.
- CPU write gating: write 0xCAFEF00D to 0x30 with `cpu_debugaccess` = 0 -> RAM[0x30] unchanged; with `cpu_debugaccess` = 1 and byteenable 4'b0011 -> only the low 16 bits are updated.
- Parity (macro on): force a bit flip in RAM[0x05], JTAG read -> `monitor_error` = 1 and `monitor_ready` = 1.

Source files
------------

// File: rtl/hw_qsys_cpu_1_cpu_debug_ocimem_pkg.sv
// Shared definitions for the Nios II OCI debug memory: jdo field positions,
// FSM state encoding and RAM word layout.
// Optional feature macro: HW_QSYS_OCIMEM_PARITY_EN (per-byte even parity in RAM).
package hw_qsys_cpu_1_cpu_debug_ocimem_pkg;

    localparam int unsigned JDO_W             = 38;
    localparam int unsigned JDO_ADDR_LSB      = 10;
    localparam int unsigned JDO_ADDR_MSB      = 17;
    localparam int unsigned JDO_RD_AFTER_LOAD = 25;
    localparam int unsigned JDO_WDATA_LSB     = 3;
    localparam int unsigned JDO_WDATA_MSB     = 34;
    localparam int unsigned JDO_CLR_READY     = 34;
    localparam int unsigned JDO_CLR_ERROR     = 35;

`ifdef HW_QSYS_OCIMEM_PARITY_EN
    localparam int unsigned PARITY_W = 4;
`else
    localparam int unsigned PARITY_W = 0;
`endif
    localparam int unsigned RAM_W = 32 + PARITY_W;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_RD      = 2'd1,
        ST_RD_WAIT = 2'd2,
        ST_WR      = 2'd3
    } ocimem_state_e;

    // Even parity per byte: bit i makes byte i plus parity an even count of ones.
    function automatic logic [3:0] byte_parity(input logic [31:0] d);
        logic [3:0] p;
        for (int unsigned i = 0; i < 4; i++) begin
            p[i] = ^d[8*i +: 8];
        end
        return p;
    endfunction

endpackage

// File: rtl/hw_qsys_cpu_1_cpu_debug_ocimem_ram.sv
// Single-port synchronous debug RAM with byte enables and a registered read port.
// With HW_QSYS_OCIMEM_PARITY_EN the word carries one parity bit per byte lane and
// perr_o flags a mismatch on the registered read word; otherwise perr_o is 0.
module hw_qsys_cpu_1_cpu_debug_ocimem_ram
    import hw_qsys_cpu_1_cpu_debug_ocimem_pkg::*;
#(
    parameter int unsigned ADDR_W = 8
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic [ADDR_W-1:0] addr_i,
    input  logic              we_i,
    input  logic              re_i,
    input  logic [3:0]        be_i,
    input  logic [31:0]       wdata_i,
    output logic [31:0]       q_o,
    output logic              perr_o
);

    logic [RAM_W-1:0] mem [2**ADDR_W];
    logic [RAM_W-1:0] q_q;
    logic [RAM_W-1:0] wword;

`ifdef HW_QSYS_OCIMEM_PARITY_EN
    assign wword  = {byte_parity(wdata_i), wdata_i};
    assign perr_o = (byte_parity(q_q[31:0]) != q_q[RAM_W-1:32]);
`else
    assign wword  = wdata_i;
    assign perr_o = 1'b0;
`endif

    assign q_o = q_q[31:0];

    // Byte-lane write; contents are deliberately not reset.
    always_ff @(posedge clk) begin
        if (we_i) begin
            for (int unsigned i = 0; i < 4; i++) begin
                if (be_i[i]) begin
                    mem[addr_i][8*i +: 8] <= wword[8*i +: 8];
`ifdef HW_QSYS_OCIMEM_PARITY_EN
                    mem[addr_i][32+i] <= wword[32+i];
`endif
                end
            end
        end
    end

    // Registered read word, updated only on a read so it holds between reads.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            q_q <= '0;
        end else if (re_i) begin
            q_q <= mem[addr_i];
        end
    end

endmodule

// File: rtl/hw_qsys_cpu_1_cpu_debug_ocimem.sv
// Nios II OCI debug memory controller: JTAG command FSM, CPU slave arbitration
// and the address/data mux in front of the shared debug RAM.
// Optional feature macro: HW_QSYS_OCIMEM_PARITY_EN (JTAG read parity errors
// raise monitor_error).
module hw_qsys_cpu_1_cpu_debug_ocimem
    import hw_qsys_cpu_1_cpu_debug_ocimem_pkg::*;
#(
    parameter int unsigned ADDR_W = 8
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic [JDO_W-1:0]  jdo,
    input  logic              take_action_ocimem_a,
    input  logic              take_action_ocimem_b,
    input  logic              take_no_action_ocimem_a,
    input  logic [ADDR_W-1:0] cpu_address,
    input  logic              cpu_read,
    input  logic              cpu_write,
    input  logic [31:0]       cpu_writedata,
    input  logic [3:0]        cpu_byteenable,
    input  logic              cpu_debugaccess,
    output logic [31:0]       cpu_readdata,
    output logic              cpu_waitrequest,
    output logic [ADDR_W-1:0] MonAReg,
    output logic [31:0]       MonDReg,
    output logic              monitor_ready,
    output logic              monitor_error
);

    ocimem_state_e     state_q, state_d;
    logic [ADDR_W-1:0] mon_a_q, mon_a_d;
    logic [31:0]       mon_d_q, mon_d_d;
    logic              ready_q, ready_d;
    logic              error_q, error_d;
    logic              cpu_rd_pend_q;
    logic [31:0]       cpu_hold_q;

    logic              jtag_strobe, cpu_req, cpu_accept, cpu_we, cpu_re;
    logic [7:0]        jdo_addr;
    logic [ADDR_W-1:0] load_addr;
    logic              ram_we, ram_re;
    logic [ADDR_W-1:0] ram_addr;
    logic [3:0]        ram_be;
    logic [31:0]       ram_wdata, ram_q;
    logic              ram_perr;
    logic              unused_jdo;

    assign unused_jdo = ^{jdo[2:0], jdo[37:36]};
    assign jdo_addr   = jdo[JDO_ADDR_MSB:JDO_ADDR_LSB];
    assign load_addr  = ADDR_W'(jdo_addr);

    assign jtag_strobe     = take_action_ocimem_a | take_action_ocimem_b;
    assign cpu_req         = cpu_read | cpu_write;
    assign cpu_accept      = cpu_req && (state_q == ST_IDLE) && !jtag_strobe;
    assign cpu_waitrequest = cpu_req && !cpu_accept;
    // Writes without debugaccess are accepted but never reach the RAM.
    assign cpu_we          = cpu_accept && cpu_write && cpu_debugaccess;
    assign cpu_re          = cpu_accept && cpu_read && !cpu_write;

    // RAM port mux: JTAG owns the port in RD/WR, the CPU otherwise.
    always_comb begin
        ram_addr  = cpu_address;
        ram_we    = cpu_we;
        ram_re    = cpu_re;
        ram_be    = cpu_byteenable;
        ram_wdata = cpu_writedata;
        case (state_q)
            ST_RD: begin
                ram_addr = mon_a_q;
                ram_we   = 1'b0;
                ram_re   = 1'b1;
            end
            ST_WR: begin
                ram_addr  = mon_a_q;
                ram_we    = 1'b1;
                ram_re    = 1'b0;
                ram_be    = '1;
                ram_wdata = mon_d_q;
            end
            default: ;
        endcase
    end

    hw_qsys_cpu_1_cpu_debug_ocimem_ram #(
        .ADDR_W (ADDR_W)
    ) u_ram (
        .clk     (clk),
        .reset_n (reset_n),
        .addr_i  (ram_addr),
        .we_i    (ram_we),
        .re_i    (ram_re),
        .be_i    (ram_be),
        .wdata_i (ram_wdata),
        .q_o     (ram_q),
        .perr_o  (ram_perr)
    );

    // JTAG command FSM; flag clears are applied first so a same-cycle set wins.
    always_comb begin
        state_d = state_q;
        mon_a_d = mon_a_q;
        mon_d_d = mon_d_q;
        ready_d = ready_q;
        error_d = error_q;
        if (take_no_action_ocimem_a) begin
            if (jdo[JDO_CLR_READY]) ready_d = 1'b0;
            if (jdo[JDO_CLR_ERROR]) error_d = 1'b0;
        end
        case (state_q)
            ST_IDLE: begin
                if (take_action_ocimem_a) begin
                    mon_a_d = load_addr;
                    if (jdo[JDO_RD_AFTER_LOAD]) begin
                        ready_d = 1'b0;
                        state_d = ST_RD;
                    end else begin
                        ready_d = 1'b1;
                    end
                    if (take_action_ocimem_b) error_d = 1'b1;
                end else if (take_action_ocimem_b) begin
                    mon_d_d = jdo[JDO_WDATA_MSB:JDO_WDATA_LSB];
                    ready_d = 1'b0;
                    state_d = ST_WR;
                end
            end
            ST_RD: begin
                state_d = ST_RD_WAIT;
                if (jtag_strobe) error_d = 1'b1;
            end
            ST_RD_WAIT: begin
                mon_d_d = ram_q;
                mon_a_d = mon_a_q + ADDR_W'(1);
                ready_d = 1'b1;
                state_d = ST_IDLE;
                if (jtag_strobe || ram_perr) error_d = 1'b1;
            end
            ST_WR: begin
                mon_a_d = mon_a_q + ADDR_W'(1);
                ready_d = 1'b1;
                state_d = ST_IDLE;
                if (jtag_strobe) error_d = 1'b1;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // FSM and JTAG-visible register state.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= ST_IDLE;
            mon_a_q <= '0;
            mon_d_q <= '0;
            ready_q <= 1'b0;
            error_q <= 1'b0;
        end else begin
            state_q <= state_d;
            mon_a_q <= mon_a_d;
            mon_d_q <= mon_d_d;
            ready_q <= ready_d;
            error_q <= error_d;
        end
    end

    // The RAM q register is shared with JTAG reads, so the CPU read word is
    // captured here to keep cpu_readdata stable until the next CPU read.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cpu_rd_pend_q <= 1'b0;
            cpu_hold_q    <= '0;
        end else begin
            cpu_rd_pend_q <= cpu_re;
            if (cpu_rd_pend_q) cpu_hold_q <= ram_q;
        end
    end

    assign cpu_readdata  = cpu_rd_pend_q ? ram_q : cpu_hold_q;
    assign MonAReg       = mon_a_q;
    assign MonDReg       = mon_d_q;
    assign monitor_ready = ready_q;
    assign monitor_error = error_q;

endmodule

// File: tb/tb_hw_qsys_cpu_1_cpu_debug_ocimem.sv
// Self-checking bench for hw_qsys_cpu_1_cpu_debug_ocimem: directed vector table,
// hand-written multi-cycle sequences and a randomized transaction-level model.
module tb_hw_qsys_cpu_1_cpu_debug_ocimem;

    localparam int unsigned ADDR_W = 8;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic [37:0] jdo = '0;
    logic        ta_a = 1'b0, ta_b = 1'b0, tna_a = 1'b0;
    logic [7:0]  cpu_address = '0;
    logic        cpu_read = 1'b0, cpu_write = 1'b0, cpu_debugaccess = 1'b0;
    logic [31:0] cpu_writedata = '0;
    logic [3:0]  cpu_byteenable = '0;
    logic [31:0] cpu_readdata;
    logic        cpu_waitrequest;
    logic [7:0]  MonAReg;
    logic [31:0] MonDReg;
    logic        monitor_ready, monitor_error;

    always #5 clk = ~clk;

    hw_qsys_cpu_1_cpu_debug_ocimem #(
        .ADDR_W (ADDR_W)
    ) dut (
        .clk                     (clk),
        .reset_n                 (reset_n),
        .jdo                     (jdo),
        .take_action_ocimem_a    (ta_a),
        .take_action_ocimem_b    (ta_b),
        .take_no_action_ocimem_a (tna_a),
        .cpu_address             (cpu_address),
        .cpu_read                (cpu_read),
        .cpu_write               (cpu_write),
        .cpu_writedata           (cpu_writedata),
        .cpu_byteenable          (cpu_byteenable),
        .cpu_debugaccess         (cpu_debugaccess),
        .cpu_readdata            (cpu_readdata),
        .cpu_waitrequest         (cpu_waitrequest),
        .MonAReg                 (MonAReg),
        .MonDReg                 (MonDReg),
        .monitor_ready           (monitor_ready),
        .monitor_error           (monitor_error)
    );

    typedef enum logic [2:0] {
        OP_LOAD, OP_LOADRD, OP_AB, OP_JWR, OP_CWR, OP_CRD, OP_CLR
    } op_e;

    typedef struct packed {
        op_e         op;
        logic [7:0]  addr;
        logic [31:0] data;
        logic [3:0]  be;
        logic        dbg;    // debugaccess for CWR, read-after-load for AB
        logic [1:0]  clr;    // {clear error, clear ready}
        logic [7:0]  exp_a;
        logic [31:0] exp_d;
        logic        exp_rdy;
        logic        exp_err;
        logic [31:0] exp_rd;
    } vec_t;

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic cpu_wait_accept(input string name);
        int waits;
        waits = 0;
        #1;
        while (cpu_waitrequest !== 1'b0 && waits < 16) begin
            @(negedge clk);
            #1;
            waits++;
        end
        if (waits >= 16) begin
            n_tests++;
            n_fail++;
            $display("FAIL %s_timeout: waitrequest still 1 after %0d cycles, required 0", name, waits);
        end
    endtask

    // Called right after a negedge; returns at a negedge with outputs settled.
    task automatic apply_op(input op_e op, input logic [7:0] addr, input logic [31:0] data,
                            input logic [3:0] be, input logic dbg, input logic [1:0] clr,
                            output logic [31:0] rdata);
        logic [37:0] j;
        j = '0;
        rdata = '0;
        case (op)
            OP_LOAD, OP_LOADRD, OP_AB: begin
                j[17:10] = addr;
                j[25] = (op == OP_LOADRD) || (op == OP_AB && dbg);
                jdo = j;
                ta_a = 1'b1;
                ta_b = (op == OP_AB);
                @(negedge clk);
                ta_a = 1'b0;
                ta_b = 1'b0;
                jdo = '0;
                if (j[25]) repeat (2) @(negedge clk);
            end
            OP_JWR: begin
                j[34:3] = data;
                jdo = j;
                ta_b = 1'b1;
                @(negedge clk);
                ta_b = 1'b0;
                jdo = '0;
                @(negedge clk);
            end
            OP_CWR: begin
                cpu_address = addr;
                cpu_writedata = data;
                cpu_byteenable = be;
                cpu_debugaccess = dbg;
                cpu_write = 1'b1;
                cpu_wait_accept("cpu_write");
                @(negedge clk);
                cpu_write = 1'b0;
            end
            OP_CRD: begin
                cpu_address = addr;
                cpu_read = 1'b1;
                cpu_wait_accept("cpu_read");
                @(negedge clk);
                cpu_read = 1'b0;
                rdata = cpu_readdata;
            end
            default: begin
                j[34] = clr[0];
                j[35] = clr[1];
                jdo = j;
                tna_a = 1'b1;
                @(negedge clk);
                tna_a = 1'b0;
                jdo = '0;
            end
        endcase
    endtask

    task automatic check_regs(input string tag, input logic [7:0] a, input logic [31:0] d,
                              input logic rdy, input logic err);
        check({tag, "_MonAReg"}, {24'd0, MonAReg}, {24'd0, a});
        check({tag, "_MonDReg"}, MonDReg, d);
        check({tag, "_ready"}, {31'd0, monitor_ready}, {31'd0, rdy});
        check({tag, "_error"}, {31'd0, monitor_error}, {31'd0, err});
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t        vecs [16];
        logic [31:0] rd;
        logic [37:0] j;
        int          stalls;
        logic [31:0] mem_m [256];
        logic [7:0]  ma;
        logic [31:0] md;
        logic        mrdy, merr;

        // op, addr, data, be, dbg, clr, exp_a, exp_d, exp_rdy, exp_err, exp_rd
        vecs[0]  = '{OP_CWR,    8'h10, 32'hDEADBEEF, 4'hF, 1'b1, 2'b00, 8'h00, 32'h00000000, 1'b0, 1'b0, 32'h0};
        vecs[1]  = '{OP_LOADRD, 8'h10, 32'h0,        4'h0, 1'b0, 2'b00, 8'h11, 32'hDEADBEEF, 1'b1, 1'b0, 32'h0};
        vecs[2]  = '{OP_LOAD,   8'hFF, 32'h0,        4'h0, 1'b0, 2'b00, 8'hFF, 32'hDEADBEEF, 1'b1, 1'b0, 32'h0};
        vecs[3]  = '{OP_JWR,    8'h00, 32'h11111111, 4'h0, 1'b0, 2'b00, 8'h00, 32'h11111111, 1'b1, 1'b0, 32'h0};
        vecs[4]  = '{OP_JWR,    8'h00, 32'h22222222, 4'h0, 1'b0, 2'b00, 8'h01, 32'h22222222, 1'b1, 1'b0, 32'h0};
        vecs[5]  = '{OP_CRD,    8'hFF, 32'h0,        4'h0, 1'b0, 2'b00, 8'h01, 32'h22222222, 1'b1, 1'b0, 32'h11111111};
        vecs[6]  = '{OP_CRD,    8'h00, 32'h0,        4'h0, 1'b0, 2'b00, 8'h01, 32'h22222222, 1'b1, 1'b0, 32'h22222222};
        vecs[7]  = '{OP_CWR,    8'h30, 32'h12345678, 4'hF, 1'b1, 2'b00, 8'h01, 32'h22222222, 1'b1, 1'b0, 32'h0};
        vecs[8]  = '{OP_CWR,    8'h30, 32'hCAFEF00D, 4'hF, 1'b0, 2'b00, 8'h01, 32'h22222222, 1'b1, 1'b0, 32'h0};
        vecs[9]  = '{OP_CRD,    8'h30, 32'h0,        4'h0, 1'b0, 2'b00, 8'h01, 32'h22222222, 1'b1, 1'b0, 32'h12345678};
        vecs[10] = '{OP_CWR,    8'h30, 32'hCAFEF00D, 4'h3, 1'b1, 2'b00, 8'h01, 32'h22222222, 1'b1, 1'b0, 32'h0};
        vecs[11] = '{OP_CRD,    8'h30, 32'h0,        4'h0, 1'b0, 2'b00, 8'h01, 32'h22222222, 1'b1, 1'b0, 32'h1234F00D};
        vecs[12] = '{OP_CLR,    8'h00, 32'h0,        4'h0, 1'b0, 2'b01, 8'h01, 32'h22222222, 1'b0, 1'b0, 32'h0};
        vecs[13] = '{OP_LOADRD, 8'h30, 32'h0,        4'h0, 1'b0, 2'b00, 8'h31, 32'h1234F00D, 1'b1, 1'b0, 32'h0};
        vecs[14] = '{OP_AB,     8'h40, 32'h0,        4'h0, 1'b0, 2'b00, 8'h40, 32'h1234F00D, 1'b1, 1'b1, 32'h0};
        vecs[15] = '{OP_CLR,    8'h00, 32'h0,        4'h0, 1'b0, 2'b10, 8'h40, 32'h1234F00D, 1'b1, 1'b0, 32'h0};

        // Reset state
        repeat (3) @(negedge clk);
        check_regs("reset", 8'h00, 32'h0, 1'b0, 1'b0);
        check("reset_readdata", cpu_readdata, 32'h0);
        check("reset_waitrequest", {31'd0, cpu_waitrequest}, 32'd0);
        reset_n = 1'b1;
        @(negedge clk);

        // Directed vector table
        for (int i = 0; i < 16; i++) begin
            apply_op(vecs[i].op, vecs[i].addr, vecs[i].data, vecs[i].be, vecs[i].dbg, vecs[i].clr, rd);
            check_regs($sformatf("vec%0d", i), vecs[i].exp_a, vecs[i].exp_d, vecs[i].exp_rdy, vecs[i].exp_err);
            if (vecs[i].op == OP_CRD) check($sformatf("vec%0d_readdata", i), rd, vecs[i].exp_rd);
        end

        // CPU arbitration: read of 0x20 collides with a read-load of 0x10
        apply_op(OP_CWR, 8'h20, 32'hA5A55A5A, 4'hF, 1'b1, 2'b00, rd);
        cpu_address = 8'h20;
        cpu_read = 1'b1;
        j = '0;
        j[17:10] = 8'h10;
        j[25] = 1'b1;
        jdo = j;
        ta_a = 1'b1;
        #1;
        check("arb_wait_with_strobe", {31'd0, cpu_waitrequest}, 32'd1);
        stalls = 1;
        @(negedge clk);
        ta_a = 1'b0;
        jdo = '0;
        #1;
        while (cpu_waitrequest === 1'b1 && stalls < 16) begin
            stalls++;
            @(negedge clk);
            #1;
        end
        check("arb_stall_cycles", stalls, 32'd3);
        @(negedge clk);
        cpu_read = 1'b0;
        check("arb_readdata", cpu_readdata, 32'hA5A55A5A);
        check_regs("arb", 8'h11, 32'hDEADBEEF, 1'b1, 1'b0);

        // Busy collision: write strobe one cycle after a read-load is dropped
        apply_op(OP_CWR, 8'h40, 32'h40404040, 4'hF, 1'b1, 2'b00, rd);
        apply_op(OP_CWR, 8'h41, 32'h0BADF00D, 4'hF, 1'b1, 2'b00, rd);
        j = '0;
        j[17:10] = 8'h40;
        j[25] = 1'b1;
        jdo = j;
        ta_a = 1'b1;
        @(negedge clk);
        ta_a = 1'b0;
        j = '0;
        j[34:3] = 32'h99999999;
        jdo = j;
        ta_b = 1'b1;
        @(negedge clk);
        ta_b = 1'b0;
        jdo = '0;
        @(negedge clk);
        check_regs("busy", 8'h41, 32'h40404040, 1'b1, 1'b1);
        apply_op(OP_CRD, 8'h41, 32'h0, 4'h0, 1'b0, 2'b00, rd);
        check("busy_ram41", rd, 32'h0BADF00D);
        apply_op(OP_CRD, 8'h40, 32'h0, 4'h0, 1'b0, 2'b00, rd);
        check("busy_ram40", rd, 32'h40404040);
        apply_op(OP_CLR, 8'h00, 32'h0, 4'h0, 1'b0, 2'b10, rd);
        check_regs("busy_clr", 8'h41, 32'h40404040, 1'b1, 1'b0);

`ifdef HW_QSYS_OCIMEM_PARITY_EN
        // Parity: corrupt one stored data bit, JTAG read must flag it
        apply_op(OP_CWR, 8'h05, 32'h0F0F0F0F, 4'hF, 1'b1, 2'b00, rd);
        dut.u_ram.mem[5][0] = ~dut.u_ram.mem[5][0];
        apply_op(OP_LOADRD, 8'h05, 32'h0, 4'h0, 1'b0, 2'b00, rd);
        check_regs("parity", 8'h06, 32'h0F0F0F0E, 1'b1, 1'b1);
        apply_op(OP_CLR, 8'h00, 32'h0, 4'h0, 1'b0, 2'b11, rd);
`endif

        // Reset in the middle of a JTAG read
        j = '0;
        j[17:10] = 8'h55;
        j[25] = 1'b1;
        jdo = j;
        ta_a = 1'b1;
        @(negedge clk);
        ta_a = 1'b0;
        jdo = '0;
        reset_n = 1'b0;
        #1;
        check_regs("midreset", 8'h00, 32'h0, 1'b0, 1'b0);
        @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);
        apply_op(OP_JWR, 8'h00, 32'h00000077, 4'h0, 1'b0, 2'b00, rd);
        check_regs("post_reset_wr", 8'h01, 32'h00000077, 1'b1, 1'b0);

        // Randomized phase against a transaction-level model
        reset_n = 1'b0;
        @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);
        ma = '0;
        md = '0;
        mrdy = 1'b0;
        merr = 1'b0;
        for (int i = 0; i < 256; i++) begin
            mem_m[i] = $urandom;
            apply_op(OP_CWR, 8'(i), mem_m[i], 4'hF, 1'b1, 2'b00, rd);
        end
        for (int n = 0; n < 300; n++) begin
            op_e         op;
            logic [7:0]  addr;
            logic [31:0] data;
            logic [3:0]  be;
            logic        dbg;
            logic [1:0]  clr;
            int unsigned sel;
            sel  = $urandom_range(0, 9);
            addr = 8'($urandom);
            data = $urandom;
            be   = 4'($urandom);
            dbg  = 1'($urandom);
            clr  = 2'($urandom);
            case (sel)
                0, 1:    op = OP_LOAD;
                2, 3:    op = OP_LOADRD;
                4:       op = OP_AB;
                5, 6:    op = OP_JWR;
                7:       op = OP_CWR;
                8:       op = OP_CRD;
                default: op = OP_CLR;
            endcase
            apply_op(op, addr, data, be, dbg, clr, rd);
            case (op)
                OP_LOAD: begin
                    ma = addr;
                    mrdy = 1'b1;
                end
                OP_LOADRD: begin
                    md = mem_m[addr];
                    ma = addr + 8'd1;
                    mrdy = 1'b1;
                end
                OP_AB: begin
                    if (dbg) begin
                        md = mem_m[addr];
                        ma = addr + 8'd1;
                    end else begin
                        ma = addr;
                    end
                    mrdy = 1'b1;
                    merr = 1'b1;
                end
                OP_JWR: begin
                    md = data;
                    mem_m[ma] = data;
                    ma = ma + 8'd1;
                    mrdy = 1'b1;
                end
                OP_CWR: begin
                    if (dbg) begin
                        for (int k = 0; k < 4; k++) begin
                            if (be[k]) mem_m[addr][8*k +: 8] = data[8*k +: 8];
                        end
                    end
                end
                OP_CRD: check($sformatf("rnd%0d_readdata", n), rd, mem_m[addr]);
                default: begin
                    if (clr[0]) mrdy = 1'b0;
                    if (clr[1]) merr = 1'b0;
                end
            endcase
            check_regs($sformatf("rnd%0d", n), ma, md, mrdy, merr);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
